dm_bytelane: RTL and testbench
==============================

# dm_bytelane

Parametrised single-port data memory for the P-series pipeline MEM stage. It supports byte, halfword and word stores with lane merging, and sign- or zero-extended loads. It flags misaligned and out-of-range accesses, and clears its array with a hardware sweep after reset. Read data is registered, so a load's result appears one cycle after the request is accepted.

## Interface
- DEPTH, 3072: number of 32-bit words in the array.
- IDX_W, 12: word-index width; must satisfy 2^IDX_W >= DEPTH.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block can accept a request (= not busy).
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- pc  in  32  PC of the requesting instruction (trace only).
- rd_valid  out  1  rdata/flags valid for the request accepted last cycle.
- rdata  out  32  extended load data; 0 for stores and faults.
- misalign  out  1  fault: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
- out_of_range  out  1  fault: addr[31:2] >= DEPTH.
- busy  out  1  clear sweep in progress.

## Operation
- FSM with two states, CLEAR and IDLE. Reset forces CLEAR with sweep counter 0.
- CLEAR: each cycle, write 0 to RAM[counter] and increment the counter. After writing DEPTH-1, go to IDLE. busy=1 and req_ready=0 throughout CLEAR.
- IDLE: busy=0, req_ready=1. A request is accepted when req_valid && req_ready.
- Store lane merge, index = addr[IDX_W+1:2]:
  - byte: writes wdata[7:0] into lane addr[1:0].
  - half: writes wdata[15:0] into lanes {addr[1],0}..{addr[1],1}.
  - word: writes all 4 lanes.
  - Untouched lanes keep their old contents.
- Load extraction uses the same lane selection, then extends bit 7 / bit 15 when sign_ext=1, otherwise zero-fills.
- Faults:
  - misalign has priority over out_of_range; only one flag is set per response.
  - A faulting request never writes the array.
  - A faulting request returns rdata=0 with its flag set for one cycle.
- Stores that do not fault produce rd_valid=1 with rdata=0 and both flags 0. Every accepted request gets exactly one response.
- Requests presented while busy are ignored: no write, no response.

## Timing
- Reset values: req_ready=0, busy=1, rd_valid=0, rdata=0, misalign=0, out_of_range=0, sweep counter=0, state=CLEAR.
- Clear sweep lasts exactly DEPTH cycles after reset deasserts. req_ready rises on the cycle after the DEPTH-1 write.
- Response latency is 1 cycle. rd_valid, rdata and the flags are registered and hold for exactly one cycle unless another request is accepted.
- Throughput is one request per cycle with back-to-back acceptance.
- Read-after-write to the same word on the next cycle returns the merged new data, because the array updates at the store's edge.
- Reset asserted mid-sweep or mid-operation:
  - All outputs return to their reset values immediately.
  - The sweep restarts from index 0.
  - A pending response is dropped.
- The array itself is not reset asynchronously; only the sweep clears it.

## Configuration
- DM_TRACE_EN defined: on every committed store, print $display("%d@%08h: *%08h <= %08h", $time, pc, {addr[31:2],2'b00}, merged_word). merged_word is the full 32-bit word after lane merging. Faulting stores and sweep writes print nothing.
- DM_TRACE_EN undefined: no display statements; pc is unused; behaviour is otherwise identical.

## Test plan
- Reset, then release: busy=1 for exactly DEPTH cycles and req_ready=0 during the sweep. A word load from 0x0000_0010 then returns 0x0000_0000.
- Store word 0x1234_5678 to 0x0000_0020, then store byte 0xAB to 0x0000_0022. A word load from 0x20 returns 0x12AB_5678. A byte load from 0x22 with sign_ext=1 returns 0xFFFF_FFAB; with sign_ext=0 it returns 0x0000_00AB.
- Store half 0x8001 to 0x0000_0032. A half load from 0x32 with sign_ext=1 returns 0xFFFF_8001; the lower half of the word is unchanged.
- Misaligned and out-of-range accesses:
  - Word store to 0x0000_0041: misalign=1, rdata=0, and a later load from 0x40 shows the word unchanged.
  - Word load with addr[31:2]=DEPTH: out_of_range=1.
  - size=11: misalign=1.
- Back-to-back store then load to the same word: rd_valid on two consecutive cycles, and the load sees the stored data.
- Assert reset mid-sweep at counter=100: outputs return to reset values and the sweep restarts at 0, so busy lasts the full DEPTH cycles after release. With DM_TRACE_EN, exactly one trace line appears per committed store.

Source files
------------

// File: rtl/dm_bytelane_if.sv
// Request/response bundle for the dm_bytelane data memory.
// master: pipeline MEM stage (drives requests, receives responses).
// slave:  dm_bytelane (receives requests, drives responses and status).
// Signals: req_valid/req_ready handshake, we, size, sign_ext, addr, wdata,
// pc (trace only); rd_valid, rdata, misalign, out_of_range, busy.
interface dm_bytelane_if;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        rd_valid;
  logic [31:0] rdata;
  logic        misalign;
  logic        out_of_range;
  logic        busy;

  modport master (
    output req_valid, we, size, sign_ext, addr, wdata, pc,
    input  req_ready, rd_valid, rdata, misalign, out_of_range, busy
  );

  modport slave (
    input  req_valid, we, size, sign_ext, addr, wdata, pc,
    output req_ready, rd_valid, rdata, misalign, out_of_range, busy
  );
endinterface

// File: rtl/dm_bytelane.sv
// dm_bytelane: single-port DEPTH x 32-bit data memory with byte/half/word
// stores (lane merge), sign/zero-extended loads, misalign/out-of-range
// fault flags and a post-reset clear sweep. Load data is registered
// (1-cycle latency, one request per cycle).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - dm_bytelane_if.slave request/response bundle
// Parameters: DEPTH (words), IDX_W (word-index width, 2^IDX_W >= DEPTH).
// Optional feature: define DM_TRACE_EN to print one line per committed store.
module dm_bytelane #(
  parameter int unsigned DEPTH = 3072,
  parameter int unsigned IDX_W = 12
) (
  input logic           clk,
  input logic           reset,
  dm_bytelane_if.slave  bus
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [29:0]      DEPTH_W = 30'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  state_t           state;
  logic [IDX_W-1:0] count;
  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             bad_align;
  logic             in_range;
  logic             fault;
  logic [31:0]      old_word;
  logic [3:0]       lane_en;
  logic [31:0]      lane_data;
  logic [31:0]      merged;
  logic [31:0]      shifted;
  logic [31:0]      load_data;
  logic             store_commit;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;

  always_comb begin
    idx       = bus.addr[IDX_W+1:2];
    accept    = bus.req_valid && bus.req_ready;
    bad_align = (bus.size == 2'b11) ||
                (bus.size == 2'b01 && bus.addr[0]) ||
                (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
    in_range  = bus.addr[31:2] < DEPTH_W;
    fault     = bad_align || !in_range;
    // Gate the read so an out-of-range index never reaches the array.
    old_word  = in_range ? mem[idx] : '0;

    // Replicate the store data across lanes, then pick lanes by enable.
    lane_en   = 4'b0000;
    lane_data = bus.wdata;
    case (bus.size)
      2'b00: begin
        lane_en   = 4'b0001 << bus.addr[1:0];
        lane_data = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = bus.addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{bus.wdata[15:0]}};
      end
      2'b10: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lane_en[i] ? lane_data[8*i +: 8] : old_word[8*i +: 8];
    end

    shifted = old_word >> {bus.addr[1:0], 3'b000};
    case (bus.size)
      2'b00:   load_data = {{24{bus.sign_ext & shifted[7]}},  shifted[7:0]};
      2'b01:   load_data = {{16{bus.sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_data = old_word;
    endcase

    store_commit = (state == IDLE) && accept && bus.we && !fault;
    mem_we       = (state == CLEAR) || store_commit;
    mem_idx      = (state == CLEAR) ? count : idx;
    mem_wdata    = (state == CLEAR) ? '0 : merged;
  end

  // Array has no reset; only the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
`ifdef DM_TRACE_EN
    if (store_commit) begin
      $display("%d@%08h: *%08h <= %08h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged);
    end
`endif
  end

`ifndef DM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= CLEAR;
      count            <= '0;
      bus.req_ready    <= 1'b0;
      bus.busy         <= 1'b1;
      bus.rd_valid     <= 1'b0;
      bus.rdata        <= '0;
      bus.misalign     <= 1'b0;
      bus.out_of_range <= 1'b0;
    end else begin
      bus.rd_valid     <= 1'b0;
      bus.rdata        <= '0;
      bus.misalign     <= 1'b0;
      bus.out_of_range <= 1'b0;
      case (state)
        CLEAR: begin
          count <= count + 1'b1;
          if (count == LAST) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            bus.rd_valid     <= 1'b1;
            bus.misalign     <= bad_align;
            bus.out_of_range <= !bad_align && !in_range;
            bus.rdata        <= (fault || bus.we) ? '0 : load_data;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bytelane.sv
module tb_dm_bytelane;
  localparam int DEPTH = 3072;
  localparam int IDX_W = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dm_bytelane_if bus ();

  dm_bytelane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // Byte-addressed reference memory.
  logic [7:0] ref_mem [DEPTH*4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic void model(input bit w, input logic [1:0] sz, input bit sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] r, output bit mis, output bit oor);
    int n;
    longint unsigned v;
    r   = '0;
    mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    oor = !mis && ((a / 4) >= DEPTH);
    if (mis || oor) return;
    n = 1 << sz;
    if (w) begin
      for (int k = 0; k < n; k++) ref_mem[a + k] = 8'((wd >> (8 * k)) & 32'hFF);
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v = v | (longint'(ref_mem[a + k]) << (8 * k));
      if (sx && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
      r = v[31:0];
    end
  endfunction

  // Present one request; it is accepted at the next edge, checked #1 later.
  task automatic req(input string tag, input bit w, input logic [1:0] sz, input bit sx,
                     input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] er;
    bit em, eo;
    bus.req_valid = 1'b1;
    bus.we        = w;
    bus.size      = sz;
    bus.sign_ext  = sx;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.pc        = $urandom;
    @(posedge clk);
    #1;
    model(w, sz, sx, a, wd, er, em, eo);
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, ".rdata"}, bus.rdata, er);
    chk({tag, ".misalign"}, 32'(bus.misalign), 32'(em));
    chk({tag, ".oor"}, 32'(bus.out_of_range), 32'(eo));
  endtask

  task automatic idle_cycle();
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle.rd_valid", 32'(bus.rd_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, ".rdata"}, bus.rdata, 32'd0);
    chk({tag, ".flags"}, {30'd0, bus.misalign, bus.out_of_range}, 32'd0);
  endtask

  // Called just after reset is released at a negedge; a store is held
  // on the bus the whole time and must be ignored.
  task automatic measure_sweep(input string tag);
    int n = 0, ready_bad = 0, rv_seen = 0;
    bus.req_valid = 1'b1;
    bus.we        = 1'b1;
    bus.size      = 2'd2;
    bus.addr      = 32'h10;
    bus.wdata     = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (bus.rd_valid) rv_seen++;
      if (bus.busy !== 1'b1) break;
      if (bus.req_ready !== 1'b0) ready_bad++;
      if (n > DEPTH + 20) break;
    end
    bus.req_valid = 1'b0;
    chk({tag, ".sweep_len"}, 32'(n), 32'(DEPTH));
    chk({tag, ".ready_low"}, 32'(ready_bad), 32'd0);
    chk({tag, ".no_resp"}, 32'(rv_seen), 32'd0);
    chk({tag, ".ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    bus.req_valid = 1'b0;
    bus.we = 1'b0;
    bus.size = 2'd0;
    bus.sign_ext = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.pc = '0;
    clear_model();

    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");
    reset = 1'b0;
    measure_sweep("sweep0");

    req("ld10", 0, 2'd2, 0, 32'h10, 0);
    chk("ld10.val", bus.rdata, 32'h0);
    req("stw20", 1, 2'd2, 0, 32'h20, 32'h12345678);
    req("stb22", 1, 2'd0, 0, 32'h22, 32'hAB);
    req("ldw20", 0, 2'd2, 0, 32'h20, 0);
    chk("ldw20.val", bus.rdata, 32'h12AB5678);
    req("ldb22s", 0, 2'd0, 1, 32'h22, 0);
    chk("ldb22s.val", bus.rdata, 32'hFFFFFFAB);
    req("ldb22z", 0, 2'd0, 0, 32'h22, 0);
    chk("ldb22z.val", bus.rdata, 32'h000000AB);
    req("stw30", 1, 2'd2, 0, 32'h30, 32'hCAFE1357);
    req("sth32", 1, 2'd1, 0, 32'h32, 32'h8001);
    req("ldh32", 0, 2'd1, 1, 32'h32, 0);
    chk("ldh32.val", bus.rdata, 32'hFFFF8001);
    req("ldh30", 0, 2'd1, 0, 32'h30, 0);
    chk("ldh30.val", bus.rdata, 32'h00001357);
    idle_cycle();

    req("stw40", 1, 2'd2, 0, 32'h40, 32'h0BADF00D);
    req("stw41", 1, 2'd2, 0, 32'h41, 32'hFFFFFFFF);
    chk("stw41.mis", 32'(bus.misalign), 32'd1);
    req("ldw40", 0, 2'd2, 0, 32'h40, 0);
    chk("ldw40.val", bus.rdata, 32'h0BADF00D);
    req("ldoor", 0, 2'd2, 0, 32'(DEPTH) << 2, 0);
    chk("ldoor.flag", 32'(bus.out_of_range), 32'd1);
    req("stoor", 1, 2'd0, 0, (32'(DEPTH) << 2) + 1, 32'h55);
    req("sz11", 0, 2'd3, 0, 32'h44, 0);
    chk("sz11.mis", 32'(bus.misalign), 32'd1);
    req("misoor", 0, 2'd2, 0, 32'hFFFF_FFF2, 0);
    req("last", 1, 2'd1, 0, (32'(DEPTH) << 2) - 2, 32'h7E57);
    req("lastld", 0, 2'd2, 0, (32'(DEPTH) << 2) - 4, 0);
    req("b2b_st", 1, 2'd2, 0, 32'h50, 32'hA5A5_0F0F);
    req("b2b_ld", 0, 2'd2, 0, 32'h50, 0);
    chk("b2b_ld.val", bus.rdata, 32'hA5A5_0F0F);
    idle_cycle();

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = $urandom_range(0, 127);
        7: a = 32'((DEPTH * 4) - 8 + $urandom_range(0, 15));
        8: a = $urandom;
        default: a = $urandom_range(0, DEPTH * 4 - 1);
      endcase
      sz = 2'($urandom_range(0, 3));
      req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end

    req("pend", 0, 2'd2, 0, 32'h20, 0);
    #1 reset = 1'b1;
    #1 chk_reset_vals("rst_op");
    @(negedge clk) reset = 1'b0;
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk) reset = 1'b0;
    clear_model();
    measure_sweep("sweep1");
    req("cleared20", 0, 2'd2, 0, 32'h20, 0);
    req("cleared50", 0, 2'd2, 0, 32'h50, 0);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
